varredura_mux: RTL and testbench

//   Scan sequencer sitting directly upstream of the 4:1 dataflow mux (d0..d3, s0, s1 -> y).
//   On a start request it drives the mux selects {s1,s0} through 00,01,10,11.
//   It holds each select for DWELL cycles, then samples the mux output y into bit [idx] of a word.
//   The assembled 4-bit word is published with a one-cycle done pulse.

---
 rtl/varredura_mux_pkg.sv | 5 +
 rtl/varredura_mux_contador.sv | 17 +
 rtl/varredura_mux.sv | 66 ++++++
 tb/tb_varredura_mux.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/varredura_mux_pkg.sv
// varredura_mux_pkg: scan FSM state encodings and select count shared by the scan sequencer
package varredura_mux_pkg;
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_SCAN = 2'd1, ST_DONE = 2'd2} state_t;
  localparam int NSEL = 4;
endpackage

// File: rtl/varredura_mux_contador.sv
// contador_dwell: CW-bit dwell counter with clear, enable and terminal flag at DWELL-1
module contador_dwell #(
  parameter int CW = 8,
  parameter int DWELL = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic term
);
  logic [CW-1:0] cnt;
  assign term = cnt == CW'(DWELL - 1);
  always_ff @(posedge clk)
    if (!rst_n || clr) cnt <= '0;
    else if (en) cnt <= term ? '0 : cnt + 1'b1;
endmodule

// File: rtl/varredura_mux.sv
// varredura_mux: steps 4:1 mux selects 00..11, samples y after each dwell into a word with a done pulse
// AUTO_REPEAT_EN: when defined, scans repeat back-to-back after the first start
module varredura_mux
  import varredura_mux_pkg::*;
#(
  parameter int DWELL = 4,
  parameter int CW = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       y_in,
  output logic       s0,
  output logic       s1,
  output logic       busy,
  output logic       done,
  output logic [3:0] sample_q
);
  state_t state;
  logic [1:0] idx;
  logic [2:0] shadow;
  logic term;
  contador_dwell #(.CW(CW), .DWELL(DWELL)) u_cnt (
    .clk(clk), .rst_n(rst_n), .clr(state != ST_SCAN), .en(state == ST_SCAN), .term(term)
  );
  assign {s1, s0} = idx;
  // shadow shifts in from the top so after three samples it holds {y2,y1,y0}
  always_ff @(posedge clk)
    if (!rst_n) begin
      state <= ST_IDLE;
      idx <= '0;
      shadow <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      sample_q <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: if (start) begin
          state <= ST_SCAN;
          idx <= '0;
          busy <= 1'b1;
        end
        ST_SCAN: if (term) begin
          if (idx == 2'(NSEL - 1)) begin
            state <= ST_DONE;
            done <= 1'b1;
            sample_q <= {y_in, shadow};
          end else begin
            idx <= idx + 2'd1;
            shadow <= {y_in, shadow[2:1]};
          end
        end
        ST_DONE: begin
          idx <= '0;
`ifdef AUTO_REPEAT_EN
          state <= ST_SCAN;
`else
          state <= ST_IDLE;
          busy <= 1'b0;
`endif
        end
        default: state <= ST_IDLE;
      endcase
    end
endmodule

// File: tb/tb_varredura_mux.sv
// tb_varredura_mux: two scanners (DWELL=4 and DWELL=1) each driving a 4:1 mux, checked against a timing model
module tb_varredura_mux;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [1:0] start = '0;
  logic [3:0] d [2];
  logic [1:0] y, s0, s1, busy, done;
  logic [3:0] q [2];
  int cyc = 0, n_cmp = 0, n_bad = 0;
  int ph [2], t [2], done_n [2], done_at [2];
  logic [3:0] mq [2], sh [2];
  always #5 clk = ~clk;
  assign y[0] = d[0][{s1[0], s0[0]}];
  assign y[1] = d[1][{s1[1], s0[1]}];
  varredura_mux #(.DWELL(4), .CW(8)) u0 (
    .clk(clk), .rst_n(rst_n), .start(start[0]), .y_in(y[0]), .s0(s0[0]), .s1(s1[0]),
    .busy(busy[0]), .done(done[0]), .sample_q(q[0])
  );
  varredura_mux #(.DWELL(1), .CW(4)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start[1]), .y_in(y[1]), .s0(s0[1]), .s1(s1[1]),
    .busy(busy[1]), .done(done[1]), .sample_q(q[1])
  );

  function automatic int dw(input int k);
    return k == 1 ? 1 : 4;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // model: ph 0=idle 1=scanning (t = edges since start) 2=done cycle
  initial begin
    int w, i;
    for (int k = 0; k < 2; k++) begin
      ph[k] = 0; t[k] = 0; mq[k] = '0; sh[k] = '0; done_n[k] = 0; done_at[k] = -1;
    end
    forever begin
      @(posedge clk);
      cyc++;
      for (int k = 0; k < 2; k++) begin
        w = dw(k);
        if (!rst_n) begin
          ph[k] = 0; t[k] = 0; mq[k] = '0; sh[k] = '0;
        end else if (ph[k] == 0) begin
          if (start[k]) begin ph[k] = 1; t[k] = 0; end
        end else if (ph[k] == 1) begin
          t[k]++;
          if (t[k] % w == 0) begin
            i = t[k] / w - 1;
            sh[k][i] = d[k][i];
            if (t[k] == 4 * w) begin ph[k] = 2; mq[k] = sh[k]; end
          end
        end else begin
`ifdef AUTO_REPEAT_EN
          ph[k] = 1; t[k] = 0;
`else
          ph[k] = 0;
`endif
        end
      end
    end
  end

  initial begin
    int es;
    forever begin
      @(negedge clk);
      if (cyc > 0)
        for (int k = 0; k < 2; k++) begin
          es = ph[k] == 1 ? t[k] / dw(k) : ph[k] == 2 ? 3 : 0;
          chk($sformatf("busy%0d", k), int'(busy[k]), int'(ph[k] != 0));
          chk($sformatf("done%0d", k), int'(done[k]), int'(ph[k] == 2));
          chk($sformatf("sel%0d", k), int'({s1[k], s0[k]}), es);
          chk($sformatf("sample_q%0d", k), int'(q[k]), int'(mq[k]));
          if (done[k]) begin done_n[k]++; done_at[k] = cyc; end
        end
    end
  end

  task automatic pulse(input int k, output int e0);
    @(posedge clk);
    #2 start[k] = 1'b1;
    @(posedge clk);
    #1 e0 = cyc;
    #1 start[k] = 1'b0;
  endtask

  task automatic wait_done(input int k, input int budget, output int at);
    int n0 = done_n[k];
    at = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      #1;
      if (done_n[k] != n0) begin at = done_at[k]; break; end
    end
    chk($sformatf("done_seen%0d", k), done_n[k] - n0, 1);
  endtask

  initial begin
    int e0, at, a1, a2, n0;
    d[0] = '0; d[1] = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_s0", int'(s0[0]), 0);
    chk("rst_s1", int'(s1[0]), 0);
    chk("rst_busy", int'(busy[0]), 0);
    chk("rst_done", int'(done[0]), 0);
    chk("rst_q", int'(q[0]), 0);
    @(posedge clk);
    #2 rst_n = 1'b1;
`ifndef AUTO_REPEAT_EN
    d[0] = 4'b1010;
    pulse(0, e0);
    wait_done(0, 40, at);
    chk("t1_done_at", at - e0, 16);
    chk("t1_q", int'(q[0]), 4'b1010);
    chk("t1_model_q", int'(mq[0]), 4'b1010);
    d[0] = 4'b1111;
    pulse(0, e0);
    wait_done(0, 40, at);
    chk("t2_q", int'(q[0]), 4'b1111);
    pulse(0, e0);
    while (cyc < e0 + 4) @(posedge clk);
    #2 start[0] = 1'b1;
    @(posedge clk);
    #2 start[0] = 1'b0;
    wait_done(0, 40, at);
    chk("t3_done_at", at - e0, 16);
    n0 = done_n[0];
    repeat (30) @(negedge clk);
    chk("t3_extra_done", done_n[0] - n0, 0);
    pulse(0, e0);
    while (cyc < e0 + 8) @(posedge clk);
    #2 rst_n = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    chk("t4_busy", int'(busy[0]), 0);
    chk("t4_q", int'(q[0]), 0);
    n0 = done_n[0];
    repeat (25) @(negedge clk);
    chk("t4_no_done", done_n[0] - n0, 0);
    pulse(0, e0);
    wait_done(0, 40, at);
    chk("t4_restart_q", int'(q[0]), 4'b1111);
    d[1] = 4'b1001;
    pulse(1, e0);
    wait_done(1, 10, at);
    chk("t5_done_at", at - e0, 4);
    chk("t5_q", int'(q[1]), 4'b1001);
    d[0] = 4'b0110;
    @(posedge clk);
    #2 start[0] = 1'b1;
    wait_done(0, 40, a1);
    wait_done(0, 40, a2);
    start[0] = 1'b0;
    chk("held_period", a2 - a1, 18);
    repeat (30) @(negedge clk);
    chk("held_q", int'(q[0]), 4'b0110);
`else
    d[0] = 4'b1010;
    pulse(0, e0);
    wait_done(0, 40, at);
    chk("t6_done1", at - e0, 16);
    chk("t6_q1", int'(q[0]), 4'b1010);
    d[0] = 4'b0101;
    wait_done(0, 40, at);
    chk("t6_done2", at - e0, 33);
    chk("t6_q2", int'(q[0]), 4'b0101);
    wait_done(0, 40, at);
    chk("t6_done3", at - e0, 50);
    chk("t6_busy", int'(busy[0]), 1);
`endif
    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
